pos_table_sweeper: RTL
======================

// Module: pos_table_sweeper
// PURPOSE
//  Parametrised truth-table generator for an N-input boolean function given as a term mask.
//  On start it sweeps every input vector 0..2^N-1 in ascending order, one per handshake.
//  Each vector is emitted with the function value over a valid/ready stream.
//  Also counts how many vectors evaluate to 1. Feeds display/checker logic in lab benches.
// PARAMETERS
//  N      4   number of function inputs; legal 1..8; MSB of vector = first variable (x)
//  T      2**N  derived localparam: table size / term_mask width
// PORTS
//  clk         in   1      rising-edge clock
//  reset       in   1      synchronous, active-high reset
//  start       in   1      one-cycle request to begin a sweep; sampled only in IDLE
//  mode        in   1      0 = POS (mask bit = maxterm -> S=0), 1 = SOP (mask bit = minterm -> S=1)
//  term_mask   in   T      bit v set = vector v is a listed term; latched on accepted start
//  out_valid   out  1      current vector/result valid
//  out_ready   in   1      consumer accepts when out_valid & out_ready (handshake)
//  out_vec     out  N      current input vector
//  out_s       out  1      function value for out_vec
//  out_last    out  1      high with out_valid when out_vec == T-1
//  busy        out  1      high in RUN
//  done        out  1      one-cycle pulse after the final handshake
//  ones_count  out  N+1    number of accepted vectors with out_s=1; range 0..T
// BEHAVIOUR
//  Reset: state=IDLE; out_valid=0, out_vec=0, out_s=0, out_last=0, busy=0, done=0, ones_count=0,
//   latched mask/mode cleared to 0. Reset mid-sweep aborts immediately; no done pulse.
//  FSM IDLE -> RUN -> DONE -> IDLE.
//   IDLE: start=1 -> latch term_mask and mode, vec<=0, ones_count<=0, go RUN.
//   RUN: out_valid=1, busy=1. On handshake: ones_count += out_s; if vec==T-1 go DONE,
//    else vec<=vec+1. Without handshake vec, out_s, out_last hold stable (no drop of valid).
//   DONE: done=1 for exactly one cycle, out_valid=0, then IDLE. ones_count holds until next start.
//  Latency: first out_valid the cycle after start is sampled; with out_ready held high,
//   T vectors in T consecutive cycles, done on cycle T+1 after start.
//  Evaluation: out_s = mode ? mask_q[vec] : ~mask_q[vec]; purely from latched mask (changes to
//   term_mask/mode during RUN have no effect).
//  start while RUN or DONE: ignored (not queued). start and reset same cycle: reset wins.
//  vec counter N bits, no wrap: terminates at T-1. ones_count N+1 bits, cannot overflow (max T).
//  out_ready while out_valid=0: ignored.
// STRUCTURE
//  Package pos_sweep_pkg: state enum {IDLE,RUN,DONE}; mode constants MODE_POS=0, MODE_SOP=1.
//  Sub-module term_eval #(N): combinational mask[vec] select + mode inversion -> s.
//  Top holds FSM, vec counter, mask/mode registers, ones_count accumulator.
// TESTING
//  N=4, POS, mask=16'h0000, ready=1 -> 16 vectors 0..15 all s=1, out_last at 15, ones_count=16, done 1 cycle.
//  N=4, POS, mask=16'h8C0F -> s=0 at v=0,1,2,3,10,11,15; ones_count=9; SOP same mask -> ones_count=7.
//  N=4, ready toggled 1,0,0,1 repeating -> vec/s stable while stalled, no skipped/duplicate vectors, 16 beats.
//  start pulsed again at vector 5 and term_mask changed -> ignored; results match original latched mask.
//  reset asserted at vector 7 -> next cycle out_valid=0, busy=0, ones_count=0, no done; fresh start sweeps from 0.
//  N=1 and N=8 builds, SOP mask all ones -> T beats, ones_count=T (2 and 256), out_last only on final beat.

Source files
------------

// File: rtl/pos_sweep_pkg.sv
// Shared types and constants for the truth-table sweeper.
// The state encoding and mode values are imported by the top level and by term_eval.
package pos_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic MODE_POS = 1'b0;
    localparam logic MODE_SOP = 1'b1;

endpackage

// File: rtl/term_eval.sv
// Combinational function evaluation: picks the mask bit for the current vector,
// then inverts it in POS mode, where a listed term is a maxterm.
module term_eval
    import pos_sweep_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [2**N-1:0] mask_i,
    input  logic [N-1:0]    vec_i,
    input  logic            mode_i,
    output logic            s_o
);

    logic termHit;

    assign termHit = mask_i[vec_i];
    assign s_o     = (mode_i == MODE_SOP) ? termHit : ~termHit;

endmodule

// File: rtl/pos_table_sweeper.sv
// Sweeps every input vector of an N-input function over a valid/ready stream.
// It emits the function value for each vector and counts the vectors that evaluate to 1.
module pos_table_sweeper
    import pos_sweep_pkg::*;
#(
    parameter int N = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            mode,
    input  logic [2**N-1:0] term_mask,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    out_vec,
    output logic            out_s,
    output logic            out_last,
    output logic            busy,
    output logic            done,
    output logic [N:0]      ones_count
);

    localparam int          T        = 2**N;
    localparam logic [N-1:0] VEC_LAST = {N{1'b1}};

    state_e         state_q, state_d;
    logic [N-1:0]   vec_q, vec_d;
    logic [T-1:0]   mask_q, mask_d;
    logic           mode_q, mode_d;
    logic [N:0]     ones_q, ones_d;
    logic           evalS;

    // Evaluation uses only the latched mask and mode, so input changes during RUN have no effect.
    term_eval #(.N(N)) u_term_eval (
        .mask_i (mask_q),
        .vec_i  (vec_q),
        .mode_i (mode_q),
        .s_o    (evalS)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            vec_q   <= '0;
            mask_q  <= '0;
            mode_q  <= 1'b0;
            ones_q  <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            mask_q  <= mask_d;
            mode_q  <= mode_d;
            ones_q  <= ones_d;
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        mask_d  = mask_q;
        mode_d  = mode_q;
        ones_d  = ones_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mask_d  = term_mask;
                    mode_d  = mode;
                    vec_d   = '0;
                    ones_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (out_ready) begin
                    ones_d = ones_q + (N+1)'(evalS);
                    if (vec_q == VEC_LAST) begin
                        state_d = DONE;
                    end else begin
                        vec_d = vec_q + N'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // out_s is gated to zero outside RUN so the idle output does not show the inverted cleared mask.
    assign out_valid  = (state_q == RUN);
    assign busy       = (state_q == RUN);
    assign done       = (state_q == DONE);
    assign out_vec    = vec_q;
    assign out_s      = out_valid & evalS;
    assign out_last   = out_valid & (vec_q == VEC_LAST);
    assign ones_count = ones_q;

endmodule
